// File: rtl/inv_key_sched.sv
// AES-128 round-key walker: expands forward to round 10, then steps back one round per request.
// Optional INV_KEY_LAST_CACHE_EN keeps a copy of the round-10 key for single-edge rewind.
module inv_key_sched_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq_c;
  logic [7:0] inv_c;

  // Multiplicative inverse as a^254 (0 maps to 0), followed by the AES affine map.
  always_comb begin
    sq_c  = a;
    inv_c = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq_c  = gf_mul(sq_c, sq_c);
      inv_c = gf_mul(inv_c, sq_c);
    end
    s = inv_c ^ {inv_c[6:0], inv_c[7]} ^ {inv_c[5:0], inv_c[7:6]}
      ^ {inv_c[4:0], inv_c[7:5]} ^ {inv_c[3:0], inv_c[7:4]} ^ 8'h63;
  end
endmodule

module inv_key_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic         step,
  input  logic         rewind,
  output logic [127:0] rkey_out,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
`ifdef INV_KEY_LAST_CACHE_EN
  logic [127:0] cache_q, cache_d;
`endif

  function automatic logic [7:0] rcon_f(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w1p, w2p, w3p;
  logic [31:0] sb_word, rot_word, sub_word, rc_word, t_word;
  logic [31:0] f0, f1, f2, f3;
  logic [3:0]  rc_idx;
  logic [127:0] key_fwd, key_inv;

  assign w0  = key_q[127:96];
  assign w1  = key_q[95:64];
  assign w2  = key_q[63:32];
  assign w3  = key_q[31:0];
  assign w3p = w3 ^ w2;
  assign w2p = w2 ^ w1;
  assign w1p = w1 ^ w0;

  // The single S-box row serves both directions: forward uses w3, inverse the recovered w3.
  assign sb_word  = (state_q == S_READY) ? w3p : w3;
  assign rot_word = {sb_word[23:0], sb_word[31:24]};
  assign rc_idx   = (state_q == S_EXPAND) ? round_q + 4'd1 : round_q;
  assign rc_word  = {rcon_f(rc_idx), 24'h000000};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      inv_key_sched_sbox u_sbox (
        .a (rot_word[8*gi +: 8]),
        .s (sub_word[8*gi +: 8])
      );
    end
  endgenerate

  assign t_word  = sub_word ^ rc_word;
  assign f0      = w0 ^ t_word;
  assign f1      = w1 ^ f0;
  assign f2      = w2 ^ f1;
  assign f3      = w3 ^ f2;
  assign key_fwd = {f0, f1, f2, f3};
  assign key_inv = {w0 ^ t_word, w1p, w2p, w3p};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
`ifdef INV_KEY_LAST_CACHE_EN
    cache_d = cache_q;
`endif
    if (key_load) begin
      key_d   = key_in;
      round_d = 4'd0;
      state_d = S_EXPAND;
    end else begin
      case (state_q)
        S_EXPAND: begin
          key_d   = key_fwd;
          round_d = round_q + 4'd1;
          if (round_q == 4'd9) begin
            state_d = S_READY;
`ifdef INV_KEY_LAST_CACHE_EN
            cache_d = key_fwd;
`endif
          end
        end
        S_READY: begin
          if (rewind) begin
`ifdef INV_KEY_LAST_CACHE_EN
            key_d   = cache_q;
            round_d = 4'd10;
`else
            // Replay forward from the current round; no key material is lost.
            if (round_q != 4'd10) state_d = S_EXPAND;
`endif
          end else if (step && round_q != 4'd0) begin
            key_d   = key_inv;
            round_d = round_q - 4'd1;
          end
        end
        S_IDLE:  ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      round_q <= '0;
`ifdef INV_KEY_LAST_CACHE_EN
      cache_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
`ifdef INV_KEY_LAST_CACHE_EN
      cache_q <= cache_d;
`endif
    end
  end

  assign rkey_out  = key_q;
  assign round_idx = round_q;
  assign busy      = (state_q == S_EXPAND);
  assign key_valid = (state_q == S_READY);
endmodule

// File: tb/tb_inv_key_sched.sv
// Bench for inv_key_sched: a table-driven AES key-expansion model plus literal FIPS-197 vectors.
module tb_inv_key_sched;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_load = 1'b0;
  logic         step = 1'b0;
  logic         rewind = 1'b0;
  logic [127:0] rkey_out;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  localparam logic [127:0] KEY_A     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_A_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_A_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] KEY_B     = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] KEY_C     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_C_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  inv_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_load  (key_load),
    .step      (step),
    .rewind    (rewind),
    .rkey_out  (rkey_out),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[2047 - 8 * int'(x) -: 8];
  endfunction

  // Textbook AES-128 expansion: 44 words, round r key is words 4r..4r+3.
  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i - 4] ^ t;
    end
    return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endfunction

  // Behavioural model: mode 0 idle, 1 expanding, 2 ready; the key itself is derived from the table.
  logic [127:0] m_key = '0;
  int m_round = 0;
  int m_mode = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_round <= 0; m_key <= '0;
    end else if (key_load) begin
      m_key <= key_in; m_round <= 0; m_mode <= 1;
    end else if (m_mode == 1) begin
      m_round <= m_round + 1;
      if (m_round == 9) m_mode <= 2;
    end else if (m_mode == 2) begin
      if (rewind) begin
`ifdef INV_KEY_LAST_CACHE_EN
        m_round <= 10;
`else
        if (m_round < 10) m_mode <= 1;
`endif
      end else if (step && m_round > 0) begin
        m_round <= m_round - 1;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_rkey", rkey_out, (m_mode == 0) ? 128'h0 : round_key(m_key, m_round));
      check("model_round", 128'(round_idx), 128'(m_round));
      check("model_busy", 128'(busy), 128'(m_mode == 1));
      check("model_valid", 128'(key_valid), 128'(m_mode == 2));
    end
  end

  // Command pulses start one tick after a rising edge and span exactly one edge.
  task automatic pulse(input logic kl, input logic st, input logic rw, input logic [127:0] k);
    key_in = k; key_load = kl; step = st; rewind = rw;
    @(posedge clk); #1;
    key_load = 1'b0; step = 1'b0; rewind = 1'b0;
  endtask

  task automatic do_load(input logic [127:0] k);
    $display("load key %h", k);
    pulse(1'b1, 1'b0, 1'b0, k);
  endtask

  task automatic do_step();
    pulse(1'b0, 1'b1, 1'b0, key_in);
    $display("step  -> round %0d key %h", round_idx, rkey_out);
  endtask

  task automatic do_rewind();
    pulse(1'b0, 1'b0, 1'b1, key_in);
    $display("rewind -> round %0d busy %0b valid %0b", round_idx, busy, key_valid);
  endtask

  task automatic wait_valid(input string name, input int exp_edges);
    int n = 0;
    while (!key_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 128'(n), 128'(exp_edges));
    $display("valid after %0d edges, key %h", n, rkey_out);
  endtask

  task automatic wait_round(input int r);
    int n = 0;
    while (round_idx != 4'(r) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_round", 128'(round_idx), 128'(r));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rkey"}, rkey_out, 128'h0);
    check({tag, "_round"}, 128'(round_idx), 128'h0);
    check({tag, "_busy"}, 128'(busy), 128'h0);
    check({tag, "_valid"}, 128'(key_valid), 128'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    chk_on = 1'b1;
    @(posedge clk); #1;

    // Model pins against the published expansion of the FIPS-197 key.
    check("pin_model_a10", round_key(KEY_A, 10), KEY_A_R10);
    check("pin_model_c10", round_key(KEY_C, 10), KEY_C_R10);

    do_load(KEY_A);
    check("load_busy", 128'(busy), 128'h1);
    wait_valid("expand_len", 10);
    check("a_r10", rkey_out, KEY_A_R10);
    check("a_r10_idx", 128'(round_idx), 128'd10);

    do_step();
    check("a_r9", rkey_out, KEY_A_R9);
    check("a_r9_idx", 128'(round_idx), 128'd9);
    repeat (9) do_step();
    check("a_r0", rkey_out, KEY_A);
    check("a_r0_idx", 128'(round_idx), 128'd0);
    do_step();
    check("a_r0_hold", rkey_out, KEY_A);
    check("a_r0_hold_idx", 128'(round_idx), 128'd0);

    do_rewind();
`ifdef INV_KEY_LAST_CACHE_EN
    check("rewind_valid", 128'(key_valid), 128'h1);
`else
    check("rewind_busy", 128'(busy), 128'h1);
    wait_valid("rewind_len", 10);
`endif
    check("rewind_key", rkey_out, KEY_A_R10);
    check("rewind_idx", 128'(round_idx), 128'd10);

    do_rewind();
    check("rewind_at10_idx", 128'(round_idx), 128'd10);
    repeat (3) do_step();
    do_rewind();
`ifndef INV_KEY_LAST_CACHE_EN
    wait_valid("rewind7_len", 3);
`endif
    check("rewind7_key", rkey_out, KEY_A_R10);

    // Commands other than key_load are ignored while expanding; then abort at round 4.
    do_load(KEY_B);
    do_step();
    do_rewind();
    check("expand_ignore_idx", 128'(round_idx), 128'd2);
    wait_round(4);
    do_load(KEY_C);
    check("restart_idx", 128'(round_idx), 128'd0);
    wait_valid("restart_len", 10);
    check("c_r10", rkey_out, KEY_C_R10);

    do_load(KEY_A);
    wait_round(5);
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_step();
    do_rewind();
    check_zero("post_rst");

    do_load(KEY_B);
    wait_valid("reload_len", 10);
    check("b_r10", rkey_out, round_key(KEY_B, 10));
    repeat (10) do_step();
    check("b_r0", rkey_out, KEY_B);

    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/inv_key_sched.md
INV_KEY_SCHED -- requirements
Module: inv_key_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 key_in  input  128  AES-128 cipher key (round-0 key), MSB = first key byte.
REQ-003 key_load  input  1  single-cycle request to load key_in and start expansion.
REQ-004 step  input  1  request to move rkey_out back one round (r -> r-1).
REQ-005 rewind  input  1  request to return rkey_out to the round-10 key.
REQ-006 rkey_out  output  128  current round key, registered, same byte order as key_in.
REQ-007 round_idx  output  4  round number (0..10) of rkey_out.
REQ-008 key_valid  output  1  high in READY; rkey_out is usable.
REQ-009 busy  output  1  high in EXPAND.

Function
REQ-010 The FSM SHALL have states IDLE, EXPAND and READY; encoding is free.
REQ-011 Command priority SHALL be key_load > rewind > step, with at most one command acting per edge.
REQ-012 key_load sampled in any state SHALL load key_in into the key register, set round_idx=0 and enter EXPAND.
REQ-013 In EXPAND, each edge SHALL apply one forward step: w0'=w0^SubWord(RotWord(w3))^{rcon(r+1),24'h0}, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2', then increment round_idx.
REQ-014 The block SHALL leave EXPAND for READY on the edge where round_idx becomes 10, so key_valid rises 10 edges after the key_load edge.
REQ-015 In READY with round_idx>0, step SHALL apply one inverse step in one edge: w3p=w3^w2, w2p=w2^w1, w1p=w1^w0, w0p=w0^SubWord(RotWord(w3p))^{rcon(r),24'h0}, then decrement round_idx.
REQ-016 A step at round_idx=0 SHALL be ignored, leaving all state unchanged.
REQ-017 The block SHALL ignore step and rewind in IDLE and in EXPAND.
REQ-018 rcon(1..10) SHALL be 01,02,04,08,10,20,40,80,1b,36, generated internally from round_idx.
REQ-019 The block SHALL contain exactly four SBOX instances, shared by forward and inverse steps through an input mux (w3 forward, w3p inverse).
REQ-020 rewind in READY at round_idx=10 SHALL be a no-op.
REQ-021 key_load during EXPAND SHALL abort the expansion and restart it from the new key_in.
REQ-022 busy SHALL equal (state==EXPAND), and key_valid SHALL equal (state==READY).

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, rkey_out=0, round_idx=0, key_valid=0, busy=0, and clear the cache register if present.
REQ-024 Reset asserted mid-EXPAND or mid-READY SHALL discard all key material; only a new key_load restarts operation.

Configuration
REQ-025 With INV_KEY_LAST_CACHE_EN defined, a 128-bit cache SHALL capture the round-10 key on the edge entering READY from EXPAND.
REQ-026 With INV_KEY_LAST_CACHE_EN defined, rewind in READY SHALL load the cache into the key register and set round_idx=10 in one edge, staying in READY.
REQ-027 Without INV_KEY_LAST_CACHE_EN, the cache SHALL be absent, and rewind in READY at round r<10 SHALL enter EXPAND, step forward from r and reach READY after 10-r edges.

Verification
REQ-028 key_load with key_in=2b7e151628aed2a6abf7158809cf4f3c -> busy for 10 edges, then key_valid=1, round_idx=10, rkey_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-029 After REQ-028, one step -> round_idx=9, rkey_out=ac7766f319fadc2128d12941575c006e; ten steps total -> round_idx=0, rkey_out=key_in; an eleventh step -> no change.
REQ-030 At round_idx=0, rewind -> with macro, round 10 key after 1 edge; without macro, busy for 10 edges, then the round-10 key.
REQ-031 Assert key_load with a new key at EXPAND round 4 -> expansion restarts (round_idx=0), and key_valid rises 10 edges later with the new key's round-10 key.
REQ-032 Drop rst_n at round_idx=5 of EXPAND -> all outputs 0 immediately, and step/rewind stay ignored until the next key_load.
